// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: round-robin frame scheduler feeding the SiTCP TCP TX byte
// stream from up to eight FWFT sources. Each granted frame is sent as a 3-byte
// header (sync, source id, length-1) followed by len+1 payload bytes.
//
// Source handshake: SRC_VALID[i] means SRC_DATA[i] holds a byte. A byte moves
// in the cycle where SRC_VALID[id] and SRC_RD[id] are both high. SRC_RD is
// raised only for the granted source in PAYLOAD, only when TCP_TX_FULL is low,
// the connection is open and RST is low. The source advances on the next edge.
module tcp_tx_arbiter #(
   parameter int         N_SRC    = 4,
   parameter logic [7:0] HDR_SYNC = 8'hA5
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               TCP_OPEN_ACK,
   input  logic               TCP_TX_FULL,
   output logic               TCP_TX_WR,
   output logic [7:0]         TCP_TX_DATA,
   input  logic [N_SRC-1:0]   SRC_REQ,
   input  logic [8*N_SRC-1:0] SRC_LEN,
   input  logic [N_SRC-1:0]   SRC_VALID,
   input  logic [8*N_SRC-1:0] SRC_DATA,
   output logic [N_SRC-1:0]   SRC_RD,
   output logic [N_SRC-1:0]   GRANT,
   output logic               BUSY,
   output logic               FRAME_DONE,
   output logic [15:0]        FRAME_CNT,
   output logic [15:0]        ABORT_CNT,
   output logic [2:0]         DBG_STATE
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR0    = 3'd1,
      HDR1    = 3'd2,
      HDR2    = 3'd3,
      PAYLOAD = 3'd4
   } state_t;

   localparam logic [2:0] LAST_ID = 3'(N_SRC - 1);

   state_t             state, state_nxt;
   logic [2:0]         id_q, id_nxt;
   logic [2:0]         rr_ptr, rr_nxt;
   logic [7:0]         len_q, len_nxt;
   logic [8:0]         cnt_q, cnt_nxt;
   logic [N_SRC-1:0]   grant_nxt;
   logic [N_SRC-1:0]   rd_comb;
   logic               wr_nxt;
   logic [7:0]         data_nxt;
   logic               done_nxt;
   logic [15:0]        fcnt_nxt, acnt_nxt;

   logic               pick_found;
   logic [2:0]         pick_id;
   logic [7:0]         pick_len;
   logic               cur_valid;
   logic [7:0]         cur_data;

   // Round-robin pick: first requester at or above rr_ptr, else the first below it.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = 3'd0;
      for (int m = 0; m < N_SRC; m++) begin
         if (!pick_found && SRC_REQ[m] && (3'(m) >= rr_ptr)) begin
            pick_found = 1'b1;
            pick_id    = 3'(m);
         end
      end
      for (int m = 0; m < N_SRC; m++) begin
         if (!pick_found && SRC_REQ[m] && (3'(m) < rr_ptr)) begin
            pick_found = 1'b1;
            pick_id    = 3'(m);
         end
      end
   end

   // Select the picked source's length and the granted source's FWFT byte.
   always_comb begin
      pick_len  = 8'h00;
      cur_valid = 1'b0;
      cur_data  = 8'h00;
      for (int k = 0; k < N_SRC; k++) begin
         if (3'(k) == pick_id) begin
            pick_len = SRC_LEN[8*k +: 8];
         end
         if (3'(k) == id_q) begin
            cur_valid = SRC_VALID[k];
            cur_data  = SRC_DATA[8*k +: 8];
         end
      end
   end

   // Next-state and next-output logic; connection loss overrides every active state.
   always_comb begin
      state_nxt = state;
      id_nxt    = id_q;
      len_nxt   = len_q;
      cnt_nxt   = cnt_q;
      rr_nxt    = rr_ptr;
      grant_nxt = GRANT;
      wr_nxt    = 1'b0;
      data_nxt  = TCP_TX_DATA;
      done_nxt  = 1'b0;
      rd_comb   = '0;
      fcnt_nxt  = FRAME_CNT;
      acnt_nxt  = ABORT_CNT;
      if ((state != IDLE) && !TCP_OPEN_ACK) begin
         state_nxt = IDLE;
         grant_nxt = '0;
         acnt_nxt  = ABORT_CNT + 16'd1;
      end else begin
         case (state)
            IDLE: begin
               if (TCP_OPEN_ACK && pick_found) begin
                  id_nxt  = pick_id;
                  len_nxt = pick_len;
                  cnt_nxt = {1'b0, pick_len} + 9'd1;
                  for (int k = 0; k < N_SRC; k++) begin
                     grant_nxt[k] = (3'(k) == pick_id);
                  end
                  rr_nxt    = (pick_id == LAST_ID) ? 3'd0 : pick_id + 3'd1;
                  state_nxt = HDR0;
               end
            end
            HDR0: begin
               if (!TCP_TX_FULL) begin
                  wr_nxt    = 1'b1;
                  data_nxt  = HDR_SYNC;
                  state_nxt = HDR1;
               end
            end
            HDR1: begin
               if (!TCP_TX_FULL) begin
                  wr_nxt    = 1'b1;
                  data_nxt  = {5'b00000, id_q};
                  state_nxt = HDR2;
               end
            end
            HDR2: begin
               if (!TCP_TX_FULL) begin
                  wr_nxt    = 1'b1;
                  data_nxt  = len_q;
                  state_nxt = PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (!TCP_TX_FULL && cur_valid) begin
                  for (int k = 0; k < N_SRC; k++) begin
                     rd_comb[k] = (3'(k) == id_q);
                  end
                  wr_nxt   = 1'b1;
                  data_nxt = cur_data;
                  cnt_nxt  = cnt_q - 9'd1;
                  if (cnt_q == 9'd1) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                     fcnt_nxt  = FRAME_CNT + 16'd1;
                     grant_nxt = '0;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // A pop during reset would lose a byte that is never written, so RST masks it.
   assign SRC_RD    = RST ? '0 : rd_comb;
   assign BUSY      = (state != IDLE);
   assign DBG_STATE = state;

   // State register and registered outputs; synchronous reset clears everything.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         id_q        <= 3'd0;
         len_q       <= 8'h00;
         cnt_q       <= 9'd0;
         rr_ptr      <= 3'd0;
         GRANT       <= '0;
         TCP_TX_WR   <= 1'b0;
         TCP_TX_DATA <= 8'h00;
         FRAME_DONE  <= 1'b0;
         FRAME_CNT   <= 16'd0;
         ABORT_CNT   <= 16'd0;
      end else begin
         state       <= state_nxt;
         id_q        <= id_nxt;
         len_q       <= len_nxt;
         cnt_q       <= cnt_nxt;
         rr_ptr      <= rr_nxt;
         GRANT       <= grant_nxt;
         TCP_TX_WR   <= wr_nxt;
         TCP_TX_DATA <= data_nxt;
         FRAME_DONE  <= done_nxt;
         FRAME_CNT   <= fcnt_nxt;
         ABORT_CNT   <= acnt_nxt;
      end
   end

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Bench for tcp_tx_arbiter: table-driven single-frame/backpressure sequence,
// hand-written reset, round-robin and abort sequences, and randomized runs
// checked against a frame-level scheduling model.
module tb_tcp_tx_arbiter;
   localparam int         NS  = 4;
   localparam logic [7:0] HDR = 8'hA5;

   logic              CLK = 1'b0;
   logic              RST;
   logic              TCP_OPEN_ACK;
   logic              TCP_TX_FULL;
   logic              TCP_TX_WR;
   logic [7:0]        TCP_TX_DATA;
   logic [NS-1:0]     SRC_REQ;
   logic [8*NS-1:0]   SRC_LEN;
   logic [NS-1:0]     SRC_VALID;
   logic [8*NS-1:0]   SRC_DATA;
   logic [NS-1:0]     SRC_RD;
   logic [NS-1:0]     GRANT;
   logic              BUSY;
   logic              FRAME_DONE;
   logic [15:0]       FRAME_CNT;
   logic [15:0]       ABORT_CNT;
   logic [2:0]        DBG_STATE;

   tcp_tx_arbiter #(.N_SRC(NS), .HDR_SYNC(HDR)) dut (
      .CLK(CLK), .RST(RST), .TCP_OPEN_ACK(TCP_OPEN_ACK), .TCP_TX_FULL(TCP_TX_FULL),
      .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA), .SRC_REQ(SRC_REQ),
      .SRC_LEN(SRC_LEN), .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_RD(SRC_RD),
      .GRANT(GRANT), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_CNT(FRAME_CNT),
      .ABORT_CNT(ABORT_CNT), .DBG_STATE(DBG_STATE)
   );

   // Clock and watchdog
   always #5 CLK = ~CLK;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   // Scoreboard counters
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural FWFT sources: byte store plus frame-length list per source
   logic [7:0] sbyte [NS][2048];
   logic [7:0] slen  [NS][64];
   int bhead [NS];
   int btail [NS];
   int fhead [NS];
   int ftail [NS];
   int fpos  [NS];
   logic [NS-1:0] rd_seen;

   task automatic flush_srcs();
      for (int i = 0; i < NS; i++) begin
         bhead[i] = 0; btail[i] = 0; fhead[i] = 0; ftail[i] = 0; fpos[i] = 0;
      end
   endtask

   task automatic push_len(input int s, input int lm1);
      slen[s][ftail[s]] = 8'(lm1);
      ftail[s]++;
   endtask

   task automatic push_byte(input int s, input logic [7:0] b);
      sbyte[s][btail[s]] = b;
      btail[s]++;
   endtask

   task automatic load_rand_frame(input int s, input int lm1);
      push_len(s, lm1);
      for (int k = 0; k <= lm1; k++) push_byte(s, 8'($urandom_range(255)));
   endtask

   task automatic drive_srcs(input logic [NS-1:0] vmask);
      for (int i = 0; i < NS; i++) begin
         SRC_REQ[i]         = (fhead[i] < ftail[i]);
         SRC_LEN[8*i +: 8]  = (fhead[i] < ftail[i]) ? slen[i][fhead[i]] : 8'h00;
         SRC_VALID[i]       = vmask[i] && (bhead[i] < btail[i]);
         SRC_DATA[8*i +: 8] = (bhead[i] < btail[i]) ? sbyte[i][bhead[i]] : 8'h00;
      end
   endtask

   task automatic pop_srcs(input logic [NS-1:0] rd);
      for (int i = 0; i < NS; i++) begin
         if (rd[i] && (bhead[i] < btail[i])) begin
            bhead[i]++;
            fpos[i]++;
            if (fpos[i] == int'(slen[i][fhead[i]]) + 1) begin
               fpos[i] = 0;
               fhead[i]++;
            end
         end
      end
   endtask

   // One clock: drive at negedge, sample SRC_RD before the edge, pop at the
   // edge, return 1 time unit after it so registered outputs can be sampled.
   task automatic cycle(input logic rst, input logic ack, input logic full,
                        input logic [NS-1:0] vmask);
      @(negedge CLK);
      RST          = rst;
      TCP_OPEN_ACK = ack;
      TCP_TX_FULL  = full;
      drive_srcs(vmask);
      #2;
      rd_seen = SRC_RD;
      @(posedge CLK);
      pop_srcs(rd_seen);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr"},    TCP_TX_WR, 0);
      chk({tag, "_data"},  TCP_TX_DATA, 0);
      chk({tag, "_grant"}, GRANT, 0);
      chk({tag, "_busy"},  BUSY, 0);
      chk({tag, "_done"},  FRAME_DONE, 0);
      chk({tag, "_fcnt"},  FRAME_CNT, 0);
      chk({tag, "_acnt"},  ABORT_CNT, 0);
   endtask

   // Reference model: frames are preloaded and requests stay up until a
   // source runs dry, so the byte stream follows from the round-robin rule.
   logic [8:0] exp_q[$];
   int exp_fcnt;

   task automatic run_model(input int start_ptr, input int p_full, input int p_valid,
                            input int budget, output int nwr);
      int cnt [NS];
      int bi  [NS];
      int fi  [NS];
      int p, nfr, pick, len;
      logic [NS-1:0] vm;
      logic full, rd_ok;
      exp_q.delete();
      p = start_ptr;
      nfr = 0;
      for (int i = 0; i < NS; i++) begin
         cnt[i] = ftail[i] - fhead[i]; bi[i] = bhead[i]; fi[i] = fhead[i];
      end
      pick = 0;
      while (pick >= 0) begin
         pick = -1;
         for (int k = 0; k < NS; k++)
            if (pick < 0 && cnt[(p + k) % NS] > 0) pick = (p + k) % NS;
         if (pick >= 0) begin
            len = int'(slen[pick][fi[pick]]) + 1;
            exp_q.push_back({1'b0, HDR});
            exp_q.push_back({1'b0, 8'(pick)});
            exp_q.push_back({1'b0, slen[pick][fi[pick]]});
            for (int b = 0; b < len; b++) begin
               exp_q.push_back({(b == len - 1), sbyte[pick][bi[pick]]});
               bi[pick]++;
            end
            fi[pick]++;
            cnt[pick]--;
            p = (pick + 1) % NS;
            nfr++;
         end
      end
      nwr = 0;
      for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
         full = ($urandom_range(99) < p_full);
         for (int i = 0; i < NS; i++) vm[i] = ($urandom_range(99) < p_valid);
         cycle(1'b0, 1'b1, full, vm);
         rd_ok = full ? (rd_seen == '0)
                      : (((rd_seen & ~SRC_VALID) == '0) && ($countones(rd_seen) <= 1));
         chk("rd_legal", rd_ok, 1);
         if (TCP_TX_WR) begin
            nwr++;
            chk("stream_byte", {FRAME_DONE, TCP_TX_DATA}, exp_q.pop_front());
         end else begin
            chk("done_without_wr", FRAME_DONE, 0);
         end
      end
      chk("stream_complete", exp_q.size(), 0);
      for (int c = 0; c < 3; c++) begin
         cycle(1'b0, 1'b1, 1'b0, '1);
         chk("trailing_wr", TCP_TX_WR, 0);
      end
      exp_fcnt += nfr;
      chk("model_fcnt", FRAME_CNT, exp_fcnt[15:0]);
      chk("model_busy", BUSY, 0);
   endtask

   // Vector table for single frame then backpressured frame from source 1
   typedef struct {
      logic          full;
      logic          ven;
      logic [NS-1:0] rd;
      logic          wr;
      logic [7:0]    data;
      logic          done;
      logic          busy;
   } vec_t;
   vec_t tbl[23];

   task automatic put(input int r, input logic f, input logic v, input logic [NS-1:0] rd,
                      input logic w, input logic [7:0] d, input logic dn, input logic b);
      tbl[r].full = f; tbl[r].ven = v; tbl[r].rd = rd; tbl[r].wr = w;
      tbl[r].data = d; tbl[r].done = dn; tbl[r].busy = b;
   endtask

   logic [7:0] rr_dat [5] = '{8'hB0, 8'hC1, 8'hD2, 8'hE3, 8'hB1};
   logic [7:0] rr_exp [20];
   logic [7:0] wbyte  [20];
   int         wcyc   [20];
   int nw, npop;

   initial begin
      RST = 1'b1; TCP_OPEN_ACK = 1'b0; TCP_TX_FULL = 1'b0;
      SRC_REQ = '0; SRC_LEN = '0; SRC_VALID = '0; SRC_DATA = '0;
      flush_srcs();
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      chk_reset("reset");
      exp_fcnt = 0;

      // Table: unstalled frame, then FULL during HDR1 and VALID gaps in payload
      put(0,  0,1,4'b0000,0,8'h00,0,1);
      put(1,  0,1,4'b0000,1,8'hA5,0,1);
      put(2,  0,1,4'b0000,1,8'h01,0,1);
      put(3,  0,1,4'b0000,1,8'h03,0,1);
      put(4,  0,1,4'b0010,1,8'h11,0,1);
      put(5,  0,1,4'b0010,1,8'h22,0,1);
      put(6,  0,1,4'b0010,1,8'h33,0,1);
      put(7,  0,1,4'b0010,1,8'h44,1,0);
      put(8,  0,1,4'b0000,0,8'h00,0,1);
      put(9,  0,1,4'b0000,1,8'hA5,0,1);
      put(10, 1,1,4'b0000,0,8'h00,0,1);
      put(11, 1,1,4'b0000,0,8'h00,0,1);
      put(12, 1,1,4'b0000,0,8'h00,0,1);
      put(13, 0,1,4'b0000,1,8'h01,0,1);
      put(14, 0,1,4'b0000,1,8'h03,0,1);
      put(15, 0,1,4'b0010,1,8'h55,0,1);
      put(16, 0,0,4'b0000,0,8'h00,0,1);
      put(17, 0,0,4'b0000,0,8'h00,0,1);
      put(18, 0,1,4'b0010,1,8'h66,0,1);
      put(19, 1,1,4'b0000,0,8'h00,0,1);
      put(20, 0,1,4'b0010,1,8'h77,0,1);
      put(21, 0,1,4'b0010,1,8'h88,1,0);
      put(22, 0,1,4'b0000,0,8'h00,0,0);
      flush_srcs();
      push_len(1, 3);
      push_byte(1, 8'h11); push_byte(1, 8'h22); push_byte(1, 8'h33); push_byte(1, 8'h44);
      push_len(1, 3);
      push_byte(1, 8'h55); push_byte(1, 8'h66); push_byte(1, 8'h77); push_byte(1, 8'h88);
      for (int r = 0; r < 23; r++) begin
         cycle(1'b0, 1'b1, tbl[r].full, tbl[r].ven ? 4'hF : 4'h0);
         chk($sformatf("tbl%0d_rd", r), rd_seen, tbl[r].rd);
         chk($sformatf("tbl%0d_wr", r), TCP_TX_WR, tbl[r].wr);
         if (tbl[r].wr) chk($sformatf("tbl%0d_data", r), TCP_TX_DATA, tbl[r].data);
         chk($sformatf("tbl%0d_done", r), FRAME_DONE, tbl[r].done);
         chk($sformatf("tbl%0d_busy", r), BUSY, tbl[r].busy);
         chk($sformatf("tbl%0d_grant", r), GRANT, tbl[r].busy ? 4'b0010 : 4'b0000);
      end
      chk("tbl_fcnt", FRAME_CNT, 2);

      // Reset in the middle of a payload
      flush_srcs();
      load_rand_frame(2, 7);
      for (int c = 0; c < 6; c++) cycle(1'b0, 1'b1, 1'b0, '1);
      chk("mid_busy", BUSY, 1);
      chk("mid_grant", GRANT, 4'b0100);
      cycle(1'b1, 1'b1, 1'b0, '1);
      chk_reset("midrst");
      flush_srcs();
      exp_fcnt = 0;

      // Round robin: ids 0,1,2,3,0 with one gap cycle between 4-byte frames
      push_len(0, 0); push_byte(0, rr_dat[0]);
      push_len(1, 0); push_byte(1, rr_dat[1]);
      push_len(2, 0); push_byte(2, rr_dat[2]);
      push_len(3, 0); push_byte(3, rr_dat[3]);
      push_len(0, 0); push_byte(0, rr_dat[4]);
      for (int k = 0; k < 5; k++) begin
         rr_exp[4*k]   = HDR;
         rr_exp[4*k+1] = 8'(k % 4);
         rr_exp[4*k+2] = 8'h00;
         rr_exp[4*k+3] = rr_dat[k];
      end
      nw = 0;
      for (int c = 0; c < 60 && nw < 20; c++) begin
         cycle(1'b0, 1'b1, 1'b0, '1);
         if (TCP_TX_WR) begin
            wbyte[nw] = TCP_TX_DATA;
            wcyc[nw]  = c;
            nw++;
         end
      end
      chk("rr_count", nw, 20);
      for (int n = 0; n < nw; n++) begin
         chk($sformatf("rr_byte%0d", n), wbyte[n], rr_exp[n]);
         chk($sformatf("rr_cyc%0d", n), wcyc[n] - wcyc[0], 5 * (n / 4) + n % 4);
      end
      cycle(1'b0, 1'b1, 1'b0, '1);
      chk("rr_fcnt", FRAME_CNT, 5);
      exp_fcnt = 5;

      // Abort after 2 of 8 payload bytes of source 1
      flush_srcs();
      push_len(1, 7);
      for (int k = 0; k < 8; k++) push_byte(1, 8'(8'h60 + k));
      load_rand_frame(0, 1);
      load_rand_frame(2, 1);
      npop = 0;
      for (int c = 0; c < 20 && npop < 2; c++) begin
         cycle(1'b0, 1'b1, 1'b0, '1);
         if (rd_seen[1]) npop++;
      end
      chk("abort_setup", npop, 2);
      cycle(1'b0, 1'b0, 1'b0, '1);
      chk("abort_rd", rd_seen, 0);
      chk("abort_wr", TCP_TX_WR, 0);
      chk("abort_busy", BUSY, 0);
      chk("abort_grant", GRANT, 0);
      chk("abort_acnt", ABORT_CNT, 1);
      chk("abort_fcnt", FRAME_CNT, 5);
      for (int c = 0; c < 2; c++) begin
         cycle(1'b0, 1'b0, 1'b0, '1);
         chk("abort_hold_wr", TCP_TX_WR, 0);
         chk("abort_hold_busy", BUSY, 0);
      end
      bhead[1] = btail[1]; fhead[1] = ftail[1]; fpos[1] = 0;
      run_model(2, 0, 100, 200, nw);
      chk("abort_acnt_after", ABORT_CNT, 1);

      // Boundary length 0xFF: 256 payload bytes, 259 writes
      cycle(1'b1, 1'b0, 1'b0, '0);
      flush_srcs();
      exp_fcnt = 0;
      load_rand_frame(3, 255);
      run_model(0, 0, 100, 400, nw);
      chk("boundary_writes", nw, 259);

      // Randomized multi-source traffic with FULL and VALID stalls
      flush_srcs();
      for (int s = 0; s < NS; s++) begin
         int nf;
         nf = $urandom_range(1, 3);
         for (int f = 0; f < nf; f++) load_rand_frame(s, $urandom_range(0, 40));
      end
      run_model(0, 25, 80, 6000, nw);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
